alu_seq_responder: RTL and testbench

- Sequential, handshaked 16-bit signed ALU that acts as the responder for the ALU opcode set already used by our stimulus benches.
- Accepts one operation (A, B, OP) per transaction over a valid/ready request channel.
- Add, subtract and logic ops complete in one cycle; multiply (shift-add) and divide (restoring) are iterative.
- The 32-bit signed result is returned over a valid/ready response channel. Sits between an operation issuer and the result consumer.

---
 rtl/alu_seq_responder.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_responder.sv
// Handshaked 16-bit signed ALU responder. Add, sub and logic ops finish in one cycle.
// Multiply uses shift-add and divide is restoring. Both work on magnitudes and fix the sign at the end.
module alu_seq_responder #(
  parameter int                   DATA_W      = 16,
  parameter logic [2*DATA_W-1:0]  DIV0_RESULT = {(2*DATA_W){1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [2:0]            op_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_D    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [RES_W-1:0]  ZERO_R   = {RES_W{1'b0}};
  localparam logic [RES_W-1:0]  ONE_R    = {{(RES_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   ZERO_REM = {(DATA_W+1){1'b0}};
  localparam logic [CNT_W-1:0]  ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = {CNT_W{1'b1}};

  // Unsigned magnitude of a two's-complement operand. -2^(DATA_W-1) maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    magnitude = v[DATA_W-1] ? (~v + ONE_D) : v;
  endfunction

  function automatic logic [RES_W-1:0] sext(input logic [DATA_W-1:0] v);
    sext = {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [RES_W-1:0] apply_sign(input logic neg, input logic [RES_W-1:0] v);
    apply_sign = neg ? (~v + ONE_R) : v;
  endfunction

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         op_r;
  logic               neg_r;
  logic [RES_W-1:0]   prod_r;
  logic [RES_W-1:0]   mcand_r;
  logic [DATA_W-1:0]  mplier_r;
  logic [DATA_W:0]    rem_r;
  logic [DATA_W-1:0]  quot_r;
  logic [DATA_W-1:0]  divisor_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [RES_W-1:0]   result_r;
  logic               dbz_r;
  logic               busy_r;

  logic [RES_W-1:0]   quick_s;
  logic [RES_W-1:0]   prod_next_s;
  logic [DATA_W+1:0]  div_shift_s;
  logic [DATA_W+1:0]  div_diff_s;
  logic               div_fits_s;
  logic [DATA_W:0]    rem_next_s;
  logic [DATA_W-1:0]  quot_next_s;
  logic [RES_W-1:0]   calc_final_s;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign result      = result_r;
  assign div_by_zero = dbz_r;
  assign busy        = busy_r;

  // Result of the ops that complete in the acceptance cycle
  always_comb begin
    quick_s = ZERO_R;
    case (op_code)
      OP_ADD:  quick_s = sext(op_a) + sext(op_b);
      OP_SUB:  quick_s = sext(op_a) - sext(op_b);
      OP_OR:   quick_s = sext(op_a | op_b);
      OP_AND:  quick_s = sext(op_a & op_b);
      OP_NOTA: quick_s = sext(~op_a);
      OP_NOTB: quick_s = sext(~op_b);
      default: quick_s = ZERO_R;
    endcase
  end

  // One shift-add step and one restoring-divide step per cycle
  always_comb begin
    prod_next_s  = prod_r + (mplier_r[0] ? mcand_r : ZERO_R);
    div_shift_s  = {rem_r, quot_r[DATA_W-1]};
    div_diff_s   = div_shift_s - {2'b00, divisor_r};
    div_fits_s   = ~div_diff_s[DATA_W+1];
    if (div_fits_s) begin
      rem_next_s = div_diff_s[DATA_W:0];
    end else begin
      rem_next_s = div_shift_s[DATA_W:0];
    end
    quot_next_s  = {quot_r[DATA_W-2:0], div_fits_s};
    if (op_r == OP_DIV) begin
      calc_final_s = apply_sign(neg_r, {ZERO_D, quot_next_s});
    end else begin
      calc_final_s = apply_sign(neg_r, prod_next_s);
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= ZERO_C;
      op_r        <= OP_ADD;
      neg_r       <= 1'b0;
      prod_r      <= ZERO_R;
      mcand_r     <= ZERO_R;
      mplier_r    <= ZERO_D;
      rem_r       <= ZERO_REM;
      quot_r      <= ZERO_D;
      divisor_r   <= ZERO_D;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= ZERO_R;
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            op_r       <= op_code;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (op_code == OP_DIV && op_b == ZERO_D) begin
              // Divide by zero bypasses the iteration entirely
              result_r    <= DIV0_RESULT;
              dbz_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else if (op_code == OP_MUL || op_code == OP_DIV) begin
              neg_r     <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
              cnt_r     <= ZERO_C;
              prod_r    <= ZERO_R;
              mcand_r   <= {ZERO_D, magnitude(op_a)};
              mplier_r  <= magnitude(op_b);
              rem_r     <= ZERO_REM;
              quot_r    <= magnitude(op_a);
              divisor_r <= magnitude(op_b);
              state_r   <= ST_CALC;
            end else begin
              result_r    <= quick_s;
              dbz_r       <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          prod_r   <= prod_next_s;
          mcand_r  <= {mcand_r[RES_W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
          rem_r    <= rem_next_s;
          quot_r   <= quot_next_s;
          cnt_r    <= cnt_r + ONE_C;
          if (cnt_r == CNT_LAST) begin
            result_r    <= calc_final_s;
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Self-checking bench for alu_seq_responder: directed vectors, randomized ops against an
// integer-arithmetic reference model, backpressure, and reset in the middle of an operation.
module tb_alu_seq_responder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  op_code;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_seq_responder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed integer arithmetic.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                output logic [31:0] r, output logic dz);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    r  = 32'h0000_0000;
    case (op)
      3'd0: r = 32'(sa + sb);
      3'd1: r = 32'(sa - sb);
      3'd2: r = 32'(sa * sb);
      3'd3: begin
        if (sb == 0) begin
          r  = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else begin
          r = 32'(sa / sb);
        end
      end
      3'd4: r = 32'(int'($signed(a | b)));
      3'd5: r = 32'(int'($signed(a & b)));
      3'd6: r = 32'(int'($signed(~a)));
      default: r = 32'(int'($signed(~b)));
    endcase
  endfunction

  function automatic int exp_latency(input logic [15:0] b, input logic [2:0] op);
    if (op == 3'd2 || (op == 3'd3 && b != 16'h0000)) exp_latency = 17;
    else exp_latency = 1;
  endfunction

  // Present one request at a negedge while idle; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    op_a = a; op_b = b; op_code = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); op_code = 3'($urandom);
  endtask

  // Cycles from the acceptance cycle until out_valid is seen, bounded.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = 16'h0000; op_b = 16'h0000; op_code = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h dz=%b busy=%b want 1 0 0 0 0",
               in_ready, out_valid, result, div_by_zero, busy);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_out_ready got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va [12] = '{16'h003C, 16'h0000, 16'h003C, 16'h1F40, 16'hFFD6, 16'hFFB0,
                             16'hFFB0, 16'h0BB8, 16'hFFD6, 16'h0005, 16'h8000, 16'h8000};
    logic [15:0] vb [12] = '{16'h000F, 16'h0FA0, 16'h1234, 16'h1F40, 16'hFFEB, 16'h0028,
                             16'h0028, 16'h2328, 16'hFFEB, 16'h0000, 16'h8000, 16'hFFFF};
    logic [2:0]  vo [12] = '{3'd0, 3'd1, 3'd6, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd3};
    logic [31:0] ve [12] = '{32'd75, 32'hFFFF_F060, 32'hFFFF_FFC3, 32'd64000000, 32'd882, 32'hFFFF_F380,
                             32'hFFFF_FFFE, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_8000};
    int          vl [12] = '{1, 1, 1, 17, 17, 17, 17, 17, 17, 1, 17, 17};
    logic        vd [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 12; i++) begin
      send(va[i], vb[i], vo[i]);
      wait_resp(lat);
      checks++;
      if (lat !== vl[i] || result !== ve[i] || div_by_zero !== vd[i]) begin
        failures++;
        $display("FAIL directed_%0d got lat=%0d res=%h dz=%b want lat=%0d res=%h dz=%b",
                 i, lat, result, div_by_zero, vl[i], ve[i], vd[i]);
      end
      ack();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL directed_release_%0d got rdy=%b vld=%b busy=%b want 1 0 0", i, in_ready, out_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [31:0] er;
    logic        ed;
    int lat;
    int el;
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      op = 3'($urandom);
      if (i % 3 == 0) b = 16'($signed(16'($urandom_range(0, 64))) - 16'sd32);
      model(a, b, op, er, ed);
      el = exp_latency(b, op);
      send(a, b, op);
      wait_resp(lat);
      checks++;
      if (lat !== el || result !== er || div_by_zero !== ed) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h op=%0d got lat=%0d res=%h dz=%b want lat=%0d res=%h dz=%b",
                 i, a, b, op, lat, result, div_by_zero, el, er, ed);
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] er;
    logic        ed;
    int lat;
    a = 16'($urandom);
    b = 16'($urandom);
    model(a, b, 3'd2, er, ed);
    send(a, b, 3'd2);
    wait_resp(lat);
    checks++;
    if (lat !== 17 || result !== er) begin
      failures++;
      $display("FAIL bp_first got lat=%0d res=%h want lat=17 res=%h", lat, result, er);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom); op_code = 3'($urandom);
      @(negedge clk);
      checks++;
      if (result !== er || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d got res=%h vld=%b rdy=%b busy=%b want res=%h 1 0 1",
                 i, result, out_valid, in_ready, busy, er);
      end
    end
    in_valid = 1'b0;
    ack();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_single_response got vld=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send(16'h1F40, 16'h1F40, 3'd2);
    // First negedge after acceptance is iteration 0; advance to iteration 7.
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got vld=%b busy=%b rdy=%b res=%h dz=%b want 0 0 1 0 0",
               out_valid, busy, in_ready, result, div_by_zero);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_no_result got vld=%b want 0", out_valid);
      end
    end
    send(16'h0BB8, 16'h2328, 3'd0);
    wait_resp(lat);
    checks++;
    if (lat !== 1 || result !== 32'd12000) begin
      failures++;
      $display("FAIL after_reset_add got lat=%0d res=%h want lat=1 res=%h", lat, result, 32'd12000);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
